// File: rtl/group_unpack.sv
// Expands a block-floating-point group (shared exponent + SIZE signed mantissas)
// into SIZE 18-bit floats, using one normalizer lane stepped over the elements.
module group_unpack #(
    parameter int SIZE       = 4,
    parameter int EXPONENT   = 8,
    parameter int FRACTION   = 9,
    parameter int MANT_WIDTH = 13
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [EXPONENT-1:0]                  exponent_in,
    input  logic [SIZE*MANT_WIDTH-1:0]           mantissa_in,
    input  logic                                 nan_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SIZE*(1+EXPONENT+FRACTION)-1:0] array_out,
    output logic [1:0]                           dbg_state
);
    localparam int OW = 1 + EXPONENT + FRACTION;
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PW = $clog2(MANT_WIDTH);
    localparam int EW = EXPONENT + 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [CW-1:0]        CNT_LAST = CW'(SIZE - 1);
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXPONENT) - 1);
    localparam logic signed [EW-1:0] E_ZERO   = '0;

    logic [1:0]                       state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [EXPONENT-1:0]              exp_q, exp_d;
    logic [SIZE-1:0][MANT_WIDTH-1:0]  mant_q, mant_d;
    logic                             nan_q, nan_d;
    logic [SIZE-1:0][OW-1:0]          array_q, array_d;

    // Normalizer lane, fed by the element selected by the counter.
    logic [MANT_WIDTH-1:0]     m_cur;
    logic                      sign;
    logic [MANT_WIDTH-1:0]     a;
    logic [PW-1:0]             p;
    logic [MANT_WIDTH-1:0]     norm;
    logic [FRACTION-1:0]       frac;
    logic signed [EW-1:0]      e_s;
    logic [OW-1:0]             conv_word;

    always_comb begin
        m_cur = mant_q[cnt_q];
        sign  = m_cur[MANT_WIDTH-1];
        a     = sign ? (~m_cur + 1'b1) : m_cur;
        p     = '0;
        for (int i = 0; i < MANT_WIDTH; i++) begin
            if (a[i]) p = PW'(i);
        end
        // Shift the leading one up to the MSB; the fraction sits right below it.
        norm = a << (PW'(MANT_WIDTH - 1) - p);
        frac = norm[MANT_WIDTH-2 -: FRACTION];
        e_s  = $signed(EW'(exp_q) + EW'(p) - EW'(FRACTION));

        if (nan_q) begin
            conv_word = {1'b1, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};
        end else if (a == '0) begin
            conv_word = '0;
        end else if (e_s >= E_MAX) begin
            conv_word = {sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        end else if (e_s <= E_ZERO) begin
            conv_word = {sign, {(EXPONENT+FRACTION){1'b0}}};
        end else begin
            conv_word = {sign, e_s[EXPONENT-1:0], frac};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        nan_d   = nan_q;
        array_d = array_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    exp_d   = exponent_in;
                    mant_d  = mantissa_in;
                    nan_d   = nan_in;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                array_d[cnt_q] = conv_word;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            nan_q   <= 1'b0;
            array_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            nan_q   <= nan_d;
            array_q <= array_d;
        end
    end

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign array_out = array_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_group_unpack.sv
// Self-checking bench for group_unpack: a reference model fills a scoreboard
// queue when each group is accepted; results are compared when out_valid is seen.
module tb_group_unpack;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exponent_in;
    logic [51:0] mantissa_in;
    logic        nan_in;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] array_out;
    logic [1:0]  dbg_state;

    logic [71:0] exp_q[$];
    int checks;
    int failures;

    group_unpack dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .exponent_in(exponent_in), .mantissa_in(mantissa_in), .nan_in(nan_in),
        .out_valid(out_valid), .out_ready(out_ready), .array_out(array_out),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [17:0] ref_elem(input logic [7:0] e_in, input logic signed [12:0] m,
                                             input logic nan);
        int mi, a, p, e, frac;
        logic s;
        if (nan) return 18'h3FF00;
        mi = m;
        s  = (mi < 0);
        a  = s ? -mi : mi;
        if (a == 0) return 18'h00000;
        p = 0;
        for (int i = 12; i >= 0; i--) begin
            if (((a >> i) & 1) == 1) begin
                p = i;
                break;
            end
        end
        e = int'(e_in) + p - 9;
        if (e >= 255) return {s, 8'hFF, 9'h000};
        if (e <= 0) return {s, 17'h0};
        if (p > 9) frac = (a >> (p - 9)) & 32'h1FF;
        else frac = (a << (9 - p)) & 32'h1FF;
        return {s, e[7:0], frac[8:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_group(input logic [7:0] e, input logic [12:0] m0, input logic [12:0] m1,
                               input logic [12:0] m2, input logic [12:0] m3, input logic nan,
                               input bit track);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", {71'd0, in_ready}, 72'd1);
        in_valid    = 1'b1;
        exponent_in = e;
        mantissa_in = {m3, m2, m1, m0};
        nan_in      = nan;
        tick();
        in_valid    = 1'b0;
        mantissa_in = $urandom;
        if (track)
            exp_q.push_back({ref_elem(e, m3, nan), ref_elem(e, m2, nan),
                             ref_elem(e, m1, nan), ref_elem(e, m0, nan)});
        check("in_ready_low_convert", {71'd0, in_ready}, 72'd0);
    endtask

    // Waits for the group, optionally stalls the consumer, then compares and hands off.
    task automatic collect(input int hold);
        int cyc;
        logic [71:0] snap, want;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("latency", 72'(cyc), 72'd4);
        snap = array_out;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_out_valid", {71'd0, out_valid}, 72'd1);
            check("bp_in_ready", {71'd0, in_ready}, 72'd0);
            check("bp_stable", array_out, snap);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 72'd1, 72'd0);
        end else begin
            want = exp_q.pop_front();
            check("array_out", array_out, want);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_hs", {71'd0, in_ready}, 72'd1);
        check("out_valid_after_hs", {71'd0, out_valid}, 72'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        exponent_in = '0;
        mantissa_in = '0;
        nan_in      = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_in_ready", {71'd0, in_ready}, 72'd1);
        check("reset_out_valid", {71'd0, out_valid}, 72'd0);
        check("reset_array", array_out, 72'd0);
        check("reset_state", {70'd0, dbg_state}, 72'd0);

        drive_group(8'd127, 13'd512, -13'sd768, 13'd0, 13'd4095, 1'b0, 1);
        collect(10);
        check("known_vector", exp_q.size() == 0 ? 72'd0 : 72'd1, 72'd0);
        // Back-to-back group right after the handshake.
        drive_group(8'd3, 13'd1, -13'sd1, 13'd0, 13'd0, 1'b0, 1);
        collect(0);
        drive_group(8'd254, 13'd2048, -13'sd4096, 13'd1, 13'd100, 1'b0, 1);
        collect(0);
        drive_group(8'd10, -13'sd4096, 13'd3, -13'sd4095, 13'd1000, 1'b0, 1);
        collect(2);
        drive_group(8'd50, 13'd7, -13'sd9, 13'd0, 13'd1234, 1'b1, 1);
        collect(0);

        // Reset on the second CONVERT cycle drops the group.
        drive_group(8'd200, 13'd77, 13'd88, 13'd99, 13'd111, 1'b0, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_out_valid", {71'd0, out_valid}, 72'd0);
        check("midreset_in_ready", {71'd0, in_ready}, 72'd1);
        check("midreset_array", array_out, 72'd0);
        drive_group(8'd127, 13'd512, 13'd1, 13'd2, 13'd3, 1'b0, 1);
        collect(0);
        check("slot0_after_reset", {54'd0, array_out[17:0]}, {54'd0, 18'h0FE00});

        for (int g = 0; g < 12; g++) begin
            drive_group(8'($urandom_range(0, 255)), 13'($urandom), 13'($urandom),
                        13'($urandom), 13'($urandom), ($urandom_range(0, 7) == 0), 1);
            collect($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
